// File: rtl/afifo_rd_drain_if.sv
// Read-port and output-stream bundle for afifo_rd_drain.
// Define AFIFO_RD_STATS_EN to add the stats_clr/pop_count statistics signals.
interface afifo_rd_drain_if #(
   parameter int unsigned DATA_WIDTH = 8
`ifdef AFIFO_RD_STATS_EN
   ,
   parameter int unsigned CNT_WIDTH  = 16
`endif
);

   // FIFO read port
   logic                  empty;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rinc;

   // Control and downstream stream
   logic                  flush;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_ready;
   logic [1:0]            occupancy;

`ifdef AFIFO_RD_STATS_EN
   logic                  stats_clr;
   logic [CNT_WIDTH-1:0]  pop_count;
`endif

   // Driven by the FIFO and the downstream consumer
   modport master (
      output empty,
      output rdata,
      output flush,
      output out_ready,
      input  rinc,
      input  out_valid,
      input  out_data,
      input  occupancy
`ifdef AFIFO_RD_STATS_EN
      ,
      output stats_clr,
      input  pop_count
`endif
   );

   // Seen from the drain block
   modport slave (
      input  empty,
      input  rdata,
      input  flush,
      input  out_ready,
      output rinc,
      output out_valid,
      output out_data,
      output occupancy
`ifdef AFIFO_RD_STATS_EN
      ,
      input  stats_clr,
      output pop_count
`endif
   );

endinterface

// File: rtl/afifo_rd_drain.sv
// Read-domain consumer for the async FIFO: pops into a 2-entry queue, drains on valid/ready.
// Define AFIFO_RD_STATS_EN to add a saturating pop counter with synchronous clear.
module afifo_rd_drain #(
   parameter int unsigned DATA_WIDTH = 8
`ifdef AFIFO_RD_STATS_EN
   ,
   parameter int unsigned CNT_WIDTH  = 16
`endif
) (
   input  logic              rclk,
   input  logic              r_rst,
   afifo_rd_drain_if.slave   bus_io
);

   logic [DATA_WIDTH-1:0] entry_q [2];
   logic [DATA_WIDTH-1:0] entry_d [2];
   logic                  rd_slot_q, rd_slot_d;
   logic                  wr_slot_q, wr_slot_d;
   logic [1:0]            count_q, count_d;

   logic                  push;
   logic                  accept;
   logic                  buf_full;
   logic                  buf_valid;

   // Pop decision never looks at out_ready, keeping that path register-bounded
   assign buf_full  = (count_q == 2'd2);
   assign buf_valid = (count_q != 2'd0);
   assign push      = !bus_io.empty && !bus_io.flush && !buf_full;
   assign accept    = buf_valid && bus_io.out_ready && !bus_io.flush;

   always_comb begin
      entry_d   = entry_q;
      rd_slot_d = rd_slot_q;
      wr_slot_d = wr_slot_q;
      count_d   = count_q;
      if (bus_io.flush) begin
         rd_slot_d = 1'b0;
         wr_slot_d = 1'b0;
         count_d   = 2'd0;
      end else begin
         if (push) begin
            entry_d[wr_slot_q] = bus_io.rdata;
            wr_slot_d          = ~wr_slot_q;
         end
         if (accept) begin
            rd_slot_d = ~rd_slot_q;
         end
         unique case ({push, accept})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge rclk or posedge r_rst) begin
      if (r_rst) begin
         entry_q[0] <= '0;
         entry_q[1] <= '0;
         rd_slot_q  <= 1'b0;
         wr_slot_q  <= 1'b0;
         count_q    <= 2'd0;
      end else begin
         entry_q[0] <= entry_d[0];
         entry_q[1] <= entry_d[1];
         rd_slot_q  <= rd_slot_d;
         wr_slot_q  <= wr_slot_d;
         count_q    <= count_d;
      end
   end

   always_comb begin
      bus_io.rinc      = push;
      bus_io.out_valid = buf_valid;
      bus_io.out_data  = entry_q[rd_slot_q];
      bus_io.occupancy = count_q;
   end

`ifdef AFIFO_RD_STATS_EN
   logic [CNT_WIDTH-1:0] pop_cnt_q, pop_cnt_d;

   // Clear beats a same-cycle pop; the count sticks at all-ones
   always_comb begin
      pop_cnt_d = pop_cnt_q;
      if (bus_io.stats_clr) begin
         pop_cnt_d = '0;
      end else if (push && !(&pop_cnt_q)) begin
         pop_cnt_d = pop_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge rclk or posedge r_rst) begin
      if (r_rst) begin
         pop_cnt_q <= '0;
      end else begin
         pop_cnt_q <= pop_cnt_d;
      end
   end

   assign bus_io.pop_count = pop_cnt_q;
`endif

endmodule
